level_loader: RTL and testbench

- Parametrised level loader. After a start request it walks brick indices 0..BRICK_NUM-1 of the selected level.
- Per brick it: looks up health; emits a one-cycle draw request with pixel x/y; waits DRAW_DELAY cycles for the drawer; then issues one brick-memory write.
- Sits between the game FSM (start/level/done) and the brick memory plus drawer.
- New relative to the previous loader: restartable on demand, multiple levels, optional skipping of empty bricks, live-brick count.

---
 rtl/level_loader_pkg.sv | 20 ++
 rtl/level_loader_rom.sv | 34 +++
 rtl/level_loader.sv | 93 +++++++++
 tb/tb_level_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/level_loader_pkg.sv
// Shared game constants and loader state encoding.
package level_loader_pkg;
  localparam int BRICK_NUM_DEF  = 40;
  localparam int COLS_DEF       = 10;
  localparam int BRICK_W_DEF    = 16;
  localparam int BRICK_H_DEF    = 8;
  localparam int DRAW_DELAY_DEF = 16;
  localparam int NUM_LEVELS_DEF = 3;
  localparam int HEALTH_W_DEF   = 2;
  localparam int LEVEL_W        = 4;
  localparam int PIX_W          = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DRAW  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/level_loader_rom.sv
// Per-level brick health tables; add new levels here without touching the FSM.
module level_rom
  import level_loader_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int HEALTH_W   = HEALTH_W_DEF,
  parameter int NUM_LEVELS = NUM_LEVELS_DEF
) (
  input  logic [LEVEL_W-1:0]  level,
  input  logic [ADDR_W-1:0]   index,
  output logic [HEALTH_W-1:0] health
);
  int lv, idx;

  always_comb begin
    lv     = int'(level);
    idx    = int'(index);
    health = '0;
    // Levels beyond the table count read as empty so the load clears memory.
    if (lv < NUM_LEVELS) begin
      case (lv)
        0: case (idx)
             1, 3, 4: health = HEALTH_W'(3);
             2, 33:   health = HEALTH_W'(1);
             5:       health = HEALTH_W'(2);
             default: health = '0;
           endcase
        1:       health = HEALTH_W'(1);
        2:       health = idx[0] ? '0 : HEALTH_W'(2);
        default: health = '0;
      endcase
    end
  end
endmodule

// File: rtl/level_loader.sv
// Walks every brick of the selected level: draw request, drawer wait, memory write.
module level_loader
  import level_loader_pkg::*;
#(
  parameter int BRICK_NUM  = BRICK_NUM_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int BRICK_W    = BRICK_W_DEF,
  parameter int BRICK_H    = BRICK_H_DEF,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 0,
  parameter int DRAW_DELAY = DRAW_DELAY_DEF,
  parameter int NUM_LEVELS = NUM_LEVELS_DEF,
  parameter int HEALTH_W   = HEALTH_W_DEF,
  parameter int SKIP_EMPTY = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEVEL_W-1:0]           level,
  output logic                         busy,
  output logic                         done,
  output logic                         draw,
  output logic                         write_en,
  output logic [$clog2(BRICK_NUM)-1:0] address,
  output logic [PIX_W-1:0]             x_out,
  output logic [PIX_W-1:0]             y_out,
  output logic [HEALTH_W-1:0]          health,
  output logic [$clog2(BRICK_NUM):0]   live_count
);
  localparam int ADDR_W = $clog2(BRICK_NUM);
  localparam int CNT_W  = $clog2(DRAW_DELAY + 1);

  state_t              state;
  logic [ADDR_W-1:0]   index;
  logic [CNT_W-1:0]    cnt;
  logic [LEVEL_W-1:0]  lvl;
  logic                skip_brick;

  level_rom #(
    .ADDR_W(ADDR_W), .HEALTH_W(HEALTH_W), .NUM_LEVELS(NUM_LEVELS)
  ) u_rom (
    .level(lvl), .index(index), .health(health)
  );

  assign skip_brick = (SKIP_EMPTY != 0) && (health == '0);
  assign address    = index;
  assign x_out      = PIX_W'(X_ORIGIN + (int'(index) % COLS) * BRICK_W);
  assign y_out      = PIX_W'(Y_ORIGIN + (int'(index) / COLS) * BRICK_H);

  assign busy     = (state == S_PREP) || (state == S_DRAW) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign draw     = (state == S_PREP) && !skip_brick;
  // A restart taken in WRITE suppresses that brick's write.
  assign write_en = (state == S_WRITE) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      index      <= '0;
      cnt        <= '0;
      lvl        <= '0;
      live_count <= '0;
    end else if (start) begin
      state      <= S_PREP;
      lvl        <= level;
      index      <= '0;
      live_count <= '0;
    end else begin
      unique case (state)
        S_PREP: begin
          if (skip_brick) state <= S_WRITE;
          else begin
            cnt   <= '0;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DRAW_DELAY - 1)) state <= S_WRITE;
        end
        S_WRITE: begin
          if (health != '0) live_count <= live_count + (ADDR_W+1)'(1);
          if (index == ADDR_W'(BRICK_NUM - 1)) state <= S_DONE;
          else begin
            index <= index + ADDR_W'(1);
            state <= S_PREP;
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_level_loader.sv
// Scoreboard bench: two loaders (draw-all and skip-empty) driven in lockstep.
module tb_level_loader;
  localparam int DD = 3;
  localparam int BN = 40;

  logic clk = 1'b0;
  logic reset, start;
  logic [3:0] level;
  logic busy0, done0, draw0, we0, busy1, done1, draw1, we1;
  logic [5:0] addr0, addr1;
  logic [9:0] x0, y0, x1, y1;
  logic [1:0] hp0, hp1;
  logic [6:0] live0, live1;

  always #5 clk = ~clk;

  level_loader #(.DRAW_DELAY(DD), .SKIP_EMPTY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .level(level),
    .busy(busy0), .done(done0), .draw(draw0), .write_en(we0),
    .address(addr0), .x_out(x0), .y_out(y0), .health(hp0), .live_count(live0));

  level_loader #(.DRAW_DELAY(DD), .SKIP_EMPTY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .level(level),
    .busy(busy1), .done(done1), .draw(draw1), .write_en(we1),
    .address(addr1), .x_out(x1), .y_out(y1), .health(hp1), .live_count(live1));

  typedef struct { int addr; int hp; int x; int y; } wr_t;
  wr_t wq0[$], wq1[$];
  int  dq0[$], dq1[$];
  int  cyc = 0, checks = 0, passed = 0;
  int  last_draw0 = 0;
  int  exp_t0, exp_t1, exp_live;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int tb_health(int lv, int i);
    if (lv == 1) return 1;
    if (lv == 2) return (i % 2 == 0) ? 2 : 0;
    if (lv == 0) begin
      if (i == 1 || i == 3 || i == 4) return 3;
      if (i == 2 || i == 33) return 1;
      if (i == 5) return 2;
    end
    return 0;
  endfunction

  task automatic push_exp(input int lv);
    wr_t w;
    wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
    exp_t0 = 0; exp_t1 = 0; exp_live = 0;
    for (int i = 0; i < BN; i++) begin
      w.addr = i; w.hp = tb_health(lv, i);
      w.x = (i % 10) * 16; w.y = (i / 10) * 8;
      wq0.push_back(w); wq1.push_back(w);
      dq0.push_back(i);
      exp_t0 += DD + 2;
      if (w.hp != 0) begin
        dq1.push_back(i);
        exp_t1 += DD + 2;
        exp_live++;
      end else exp_t1 += 2;
    end
  endtask

  // Scoreboard consumer: compare every draw and write against queued expectations.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (draw0) begin
      last_draw0 = cyc;
      if (dq0.size() == 0) check("draw0_extra", 1, 0);
      else check("draw0_addr", addr0, dq0.pop_front());
    end
    if (draw1) begin
      if (dq1.size() == 0) check("draw1_extra", 1, 0);
      else check("draw1_addr", addr1, dq1.pop_front());
    end
    if (we0) begin
      check("gap0", cyc - last_draw0, DD + 1);
      if (wq0.size() == 0) check("wr0_extra", 1, 0);
      else begin
        e = wq0.pop_front();
        check("wr0_addr", addr0, e.addr); check("wr0_hp", hp0, e.hp);
        check("wr0_x", x0, e.x);          check("wr0_y", y0, e.y);
      end
    end
    if (we1) begin
      if (wq1.size() == 0) check("wr1_extra", 1, 0);
      else begin
        e = wq1.pop_front();
        check("wr1_addr", addr1, e.addr); check("wr1_hp", hp1, e.hp);
        check("wr1_x", x1, e.x);          check("wr1_y", y1, e.y);
      end
    end
  end

  task automatic wait_done(input int sc);
    int d0 = -1, d1 = -1;
    for (int k = 0; k < 1000 && (d0 < 0 || d1 < 0); k++) begin
      @(negedge clk);
      if (d0 < 0 && done0) d0 = cyc;
      if (d1 < 0 && done1) d1 = cyc;
    end
    check("done_t0", d0 - sc, exp_t0);
    check("done_t1", d1 - sc, exp_t1);
    check("live0", live0, exp_live);
    check("live1", live1, exp_live);
    check("busy_end", {busy0, busy1}, 0);
    check("wq_left", wq0.size() + wq1.size(), 0);
    check("dq_left", dq0.size() + dq1.size(), 0);
  endtask

  task automatic pulse_start(input int lv);
    @(posedge clk); #1; start = 1'b1; level = 4'(lv); push_exp(lv);
    @(posedge clk); #1; start = 1'b0;
    check("busy_start", {busy0, busy1, done0, done1}, 4'b1100);
  endtask

  task automatic wait_draw0(input int a);
    int found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(negedge clk);
      if (draw0 && addr0 == 6'(a)) found = 1;
    end
    check("saw_draw0", found, 1);
  endtask

  initial begin
    int sc;
    reset = 1'b1; start = 1'b0; level = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bits", {busy0, done0, draw0, we0, busy1, done1, draw1, we1}, 0);
    check("rst_live", {live0, live1}, 0);
    check("rst_geom", {addr0, x0, y0, hp0}, 0);
    reset = 1'b0;

    // Level 0, draw-all vs skip-empty timing and live count.
    pulse_start(0); sc = cyc;
    wait_done(sc);
    check("done_hold", {done0, done1}, 2'b11);

    // Restart to level 1 while dut0 is in DRAW of brick 7.
    @(posedge clk); #1; start = 1'b1; level = 4'd0; push_exp(0);
    @(posedge clk); #1; start = 1'b0;
    wait_draw0(7);
    @(posedge clk); #1; start = 1'b1; level = 4'd1; push_exp(1);
    @(posedge clk); #1; start = 1'b0; sc = cyc;
    check("restart_idx", {addr0, addr1}, 0);
    wait_done(sc);

    // Reset mid-DRAW returns to IDLE with cleared count.
    pulse_start(2);
    wait_draw0(3);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_bits", {busy0, done0, draw0, we0, busy1, done1, draw1, we1}, 0);
    check("mrst_live", {live0, live1}, 0);
    check("mrst_addr", {addr0, hp0}, 0);
    reset = 1'b0;
    wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();

    pulse_start(2); sc = cyc;
    wait_done(sc);
    pulse_start(5); sc = cyc;
    wait_done(sc);
    check("lvl5_done", {done0, done1}, 2'b11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
